// File: rtl/uart_disp_pkg.sv
// Shared types and constants for the UART hex display path: RX state encoding,
// seven-segment glyph table (active-high, {G,F,E,D,C,B,A}) and blank-pattern helper.
package uart_disp_pkg;

  localparam int SEG_WIDTH = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_CLEANUP
  } rx_state_e;

  localparam logic [SEG_WIDTH-1:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_WIDTH-1:0] seg_blank(input bit active_low);
    return active_low ? {SEG_WIDTH{1'b1}} : {SEG_WIDTH{1'b0}};
  endfunction

endpackage

// File: rtl/hex_nibble_to_seg.sv
// Combinational hex digit decoder: nibble plus valid flag to active-high segments.
// Digits that hold no received data decode to all segments off.
module hex_nibble_to_seg
  import uart_disp_pkg::*;
(
  input  logic [3:0]           nibble,
  input  logic                 valid,
  output logic [SEG_WIDTH-1:0] seg
);

  always_comb begin
    seg = valid ? HEX_GLYPH[nibble] : {SEG_WIDTH{1'b0}};
  end

endmodule

// File: rtl/uart_hex_display_ctrl.sv
// UART receiver feeding an N-digit scrolling hex display with optional idle-timeout clear.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_hex_display_ctrl
  import uart_disp_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 217,
  parameter int NUM_DIGITS        = 4,
  parameter int ACTIVE_LOW_SEG    = 1,
  parameter int IDLE_TIMEOUT_CLKS = 0
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_L,
  input  logic                              i_RX_Serial,
  input  logic                              i_Clear,
  output logic [SEG_WIDTH*NUM_DIGITS-1:0]   o_Segments,
  output logic [NUM_DIGITS-1:0]             o_Digit_Valid,
  output logic                              o_RX_DV,
  output logic [7:0]                        o_RX_Byte,
  output logic                              o_Frame_Err,
  output logic                              o_Parity_Err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int NIB_W  = 4 * NUM_DIGITS;
  localparam int SEG_W  = SEG_WIDTH * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [SEG_W-1:0] SEG_OFF  = {NUM_DIGITS{seg_blank(ACTIVE_LOW_SEG != 0)}};

  logic             rx_p0, rx_p1;
  rx_state_e        rx_state;
  logic [CNT_W-1:0] bit_cnt_clk;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_dv, frame_err;
  logic [7:0]       rx_byte;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, parity_err;
`endif

  logic [NIB_W-1:0]      nib_d, nib_p0;
  logic [NUM_DIGITS-1:0] vld_d, vld_p0;
  logic [SEG_W-1:0]      seg_raw, seg_p1;
  logic                  to_hit;

  // Stage p0/p1: two-flop synchroniser on the asynchronous serial line
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_RX_Serial;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rx_state    <= RX_IDLE;
      bit_cnt_clk <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_dv       <= 1'b0;
      rx_byte     <= '0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          bit_cnt_clk <= '0;
          bit_idx     <= '0;
          if (!rx_p1) rx_state <= RX_START;
        end
        RX_START: begin
          // A start bit that is no longer low at mid-bit is treated as a glitch
          if (bit_cnt_clk == CNT_MID) begin
            bit_cnt_clk <= '0;
            rx_state    <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt_clk <= bit_cnt_clk + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt_clk == CNT_LAST) begin
            bit_cnt_clk <= '0;
            shreg       <= {rx_p1, shreg[7:1]};
            bit_idx     <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end
          end else begin
            bit_cnt_clk <= bit_cnt_clk + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (bit_cnt_clk == CNT_LAST) begin
            bit_cnt_clk <= '0;
            par_bit     <= rx_p1;
            rx_state    <= RX_STOP;
          end else begin
            bit_cnt_clk <= bit_cnt_clk + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (bit_cnt_clk == CNT_LAST) begin
            bit_cnt_clk <= '0;
            rx_state    <= RX_CLEANUP;
            if (!rx_p1) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shreg, par_bit}) begin
              parity_err <= 1'b1;
`endif
            end else begin
              rx_dv   <= 1'b1;
              rx_byte <= shreg;
            end
          end else begin
            bit_cnt_clk <= bit_cnt_clk + 1'b1;
          end
        end
        RX_CLEANUP: rx_state <= RX_IDLE;
        default:    rx_state <= RX_IDLE;
      endcase
    end
  end

  if (IDLE_TIMEOUT_CLKS > 0) begin : g_timeout
    localparam int TO_W = $clog2(IDLE_TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT_CLKS - 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L || rx_dv || i_Clear) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end

    // A byte accepted in the expiry cycle keeps the display alive
    assign to_hit = (to_cnt == TO_LAST) && !rx_dv;
  end else begin : g_no_timeout
    assign to_hit = 1'b0;
  end

  // Clear is applied before the load so a colliding byte still lands in digits 1:0
  always_comb begin
    nib_d = nib_p0;
    vld_d = vld_p0;
    if (i_Clear || to_hit) begin
      nib_d = '0;
      vld_d = '0;
    end
    if (rx_dv) begin
      nib_d = (nib_d << 8) | NIB_W'(rx_byte);
      vld_d = (vld_d << 2) | NUM_DIGITS'(2'b11);
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    hex_nibble_to_seg u_dec (
      .nibble (nib_d[4*k +: 4]),
      .valid  (vld_d[k]),
      .seg    (seg_raw[SEG_WIDTH*k +: SEG_WIDTH])
    );
  end

  // Stage p0 buffer / p1 segments: decoded from next-state so both land together
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      nib_p0 <= '0;
      vld_p0 <= '0;
      seg_p1 <= SEG_OFF;
    end else begin
      nib_p0 <= nib_d;
      vld_p0 <= vld_d;
      seg_p1 <= seg_raw ^ SEG_OFF;
    end
  end

  assign o_Segments    = seg_p1;
  assign o_Digit_Valid = vld_p0;
  assign o_RX_DV       = rx_dv;
  assign o_RX_Byte     = rx_byte;
  assign o_Frame_Err   = frame_err;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err  = parity_err;
`else
  assign o_Parity_Err  = 1'b0;
`endif

endmodule
